// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared sizing defaults and requester tag encoding for the memory arbiter.
package mem_ctrl_pkg;
  localparam int DW_DEF    = 8;
  localparam int M_DEF     = 8;
  localparam int N_DEF     = 8;
  localparam int AW_DEF    = M_DEF + N_DEF;
  localparam int DEPTH_DEF = M_DEF * N_DEF;
  typedef enum logic {TAG_REQ0 = 1'b0, TAG_REQ1 = 1'b1} tag_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; the pointer remembers the last accepted requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);
  logic ptr_q, ptr_d;
  always_comb begin
    grant_o = (&valid_i) ? (ptr_q ? 2'b01 : 2'b10) : valid_i;
    ptr_d   = accept_i ? grant_o[1] : ptr_q;
  end
  // Reset points at req1 so req0 wins the first tie.
  always_ff @(posedge clk) ptr_q <= !rst_n ? 1'b1 : ptr_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a 1-cycle synchronous RAM.
// S1 issues the RAM access, S2 routes the response back to the originator.
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int m  = M_DEF,
  parameter int n  = N_DEF,
  localparam int AW    = m + n,
  localparam int DEPTH = m * n
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          req0_rvalid,
  output logic [DW-1:0] req0_rdata,
  output logic          req0_err,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          req1_rvalid,
  output logic [DW-1:0] req1_rdata,
  output logic          req1_err,
  output logic          ram_en,
  output logic          write_en,
  output logic          read_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  logic [1:0] gnt;
  logic acc, rv;
  logic s1_vld_q, s1_vld_d, s1_we_q, s1_we_d, s1_oor_q, s1_oor_d;
  tag_e s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  logic [AW-1:0] s1_addr_q, s1_addr_d;
  logic [DW-1:0] s1_wdata_q, s1_wdata_d;
  logic s2_vld_q, s2_vld_d, s2_rd_q, s2_rd_d, s2_err_q, s2_err_d;
  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  ({req1_valid, req0_valid}),
    .accept_i (acc),
    .grant_o  (gnt)
  );
  assign req0_ready = gnt[0] & rst_n;
  assign req1_ready = gnt[1] & rst_n;
  assign acc        = req0_ready | req1_ready;
  always_comb begin
    s1_vld_d   = acc;
    s1_tag_d   = req1_ready ? TAG_REQ1 : TAG_REQ0;
    s1_we_d    = req1_ready ? req1_we : req0_we;
    s1_addr_d  = req1_ready ? req1_addr : req0_addr;
    s1_wdata_d = req1_ready ? req1_wdata : req0_wdata;
    s1_oor_d   = {1'b0, s1_addr_d} >= DEPTH_W;
    s2_vld_d   = s1_vld_q;
    s2_tag_d   = s1_tag_q;
    s2_rd_d    = ~s1_we_q & ~s1_oor_q;
    s2_err_d   = s1_oor_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_tag_q   <= TAG_REQ0;
      s1_we_q    <= 1'b0;
      s1_addr_q  <= '0;
      s1_wdata_q <= '0;
      s1_oor_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_tag_q   <= TAG_REQ0;
      s2_rd_q    <= 1'b0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_tag_q   <= s1_tag_d;
      s1_we_q    <= s1_we_d;
      s1_addr_q  <= s1_addr_d;
      s1_wdata_q <= s1_wdata_d;
      s1_oor_q   <= s1_oor_d;
      s2_vld_q   <= s2_vld_d;
      s2_tag_q   <= s2_tag_d;
      s2_rd_q    <= s2_rd_d;
      s2_err_q   <= s2_err_d;
    end
  end
  assign ram_en    = s1_vld_q & ~s1_oor_q & rst_n;
  assign write_en  = ram_en & s1_we_q;
  assign read_en   = ram_en & ~s1_we_q;
  assign mem_addr  = s1_addr_q;
  assign mem_wdata = s1_wdata_q;
  // Read data is only meaningful for in-range reads; everything else returns zero.
  assign rv          = s2_vld_q & rst_n;
  assign req0_rvalid = rv & (s2_tag_q == TAG_REQ0);
  assign req1_rvalid = rv & (s2_tag_q == TAG_REQ1);
  assign req0_rdata  = (req0_rvalid & s2_rd_q) ? mem_rdata : '0;
  assign req1_rdata  = (req1_rvalid & s2_rd_q) ? mem_rdata : '0;
  assign req0_err    = req0_rvalid & s2_err_q;
  assign req1_err    = req1_rvalid & s2_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with a response scoreboard and an independent monitor.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [15:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_wdata = '0, req1_wdata = '0;
  logic req0_ready, req0_rvalid, req0_err, req1_ready, req1_rvalid, req1_err;
  logic [7:0] req0_rdata, req1_rdata;
  logic ram_en, write_en, read_en;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic [7:0] ram [64];
  logic ram_init = 1'b0;
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  typedef struct {int port; logic [7:0] d; logic e; int due;} exp_t;
  exp_t q[$];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .ram_en(ram_en), .write_en(write_en), .read_en(read_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents start as 0x10+addr and are never reset afterwards.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= 8'(8'h10 + i);
      ram_init <= 1'b1;
    end else begin
      if (ram_en && write_en) ram[mem_addr[5:0]] <= mem_wdata;
      if (ram_en && read_en) mem_rdata <= ram[mem_addr[5:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (req0_rvalid && req1_rvalid) check("dual_rvalid", 1, 0);
    if (req0_rvalid || req1_rvalid) begin
      if (q.size() == 0) check("unexpected_rvalid", {req1_rvalid, req0_rvalid}, 0);
      else begin
        e = q.pop_front();
        check("resp_port", req1_rvalid, e.port);
        check("resp_data", req1_rvalid ? req1_rdata : req0_rdata, e.d);
        check("resp_err", req1_rvalid ? req1_err : req0_err, e.e);
        check("resp_cycle", cyc, e.due);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      check("missing_rvalid", 0, 1);
      void'(q.pop_front());
    end
    if (!req0_rvalid) check("idle0_out", {req0_rdata, req0_err}, 0);
    if (!req1_rvalid) check("idle1_out", {req1_rdata, req1_err}, 0);
  end

  task automatic step(input logic v0, w0, input logic [15:0] a0, input logic [7:0] d0,
                      input logic v1, w1, input logic [15:0] a1, input logic [7:0] d1,
                      input int eg, input logic [7:0] er, input logic ee);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    @(negedge clk);
    check("ready0", req0_ready, eg == 0);
    check("ready1", req1_ready, eg == 1);
    if (eg >= 0) q.push_back('{eg, er, ee, cyc + 2});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0);
  endtask

  task automatic do_reset(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      q.delete();
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_ram_en", ram_en, 0);
    end
  endtask

  initial begin
    do_reset(2);
    check("rst_mem_addr", mem_addr, 0);
    // Tie from reset: grants alternate 0,1,0,1,0,1; losers hold their command.
    step(1, 0, 16'd10, 0, 1, 0, 16'd20, 0, 0, 8'h1A, 0);
    step(1, 0, 16'd11, 0, 1, 0, 16'd20, 0, 1, 8'h24, 0);
    step(1, 0, 16'd11, 0, 1, 0, 16'd21, 0, 0, 8'h1B, 0);
    step(1, 0, 16'd12, 0, 1, 0, 16'd21, 0, 1, 8'h25, 0);
    step(1, 0, 16'd12, 0, 1, 0, 16'd22, 0, 0, 8'h1C, 0);
    step(1, 0, 16'd13, 0, 1, 0, 16'd22, 0, 1, 8'h26, 0);
    repeat (3) idle();
    // Write 0x0005=0xA5, then read it back the next cycle.
    step(1, 1, 16'h0005, 8'hA5, 0, 0, 0, 0, 0, 8'h00, 0);
    step(1, 0, 16'h0005, 0, 0, 0, 0, 0, 0, 8'hA5, 0);
    repeat (3) idle();
    // Out-of-range read on req1 and the highest in-range address.
    step(0, 0, 0, 0, 1, 0, 16'h0040, 0, 1, 8'h00, 1);
    step(1, 0, 16'h003F, 0, 0, 0, 0, 0, 0, 8'h4F, 0);
    check("oor_ram_en", ram_en, 0);
    step(1, 1, 16'h1234, 8'h77, 0, 0, 0, 0, 0, 8'h00, 1);
    check("max_ram_en", ram_en, 1);
    check("max_mem_addr", mem_addr, 16'h003F);
    check("max_read_en", read_en, 1);
    idle();
    check("oor_wr_ram_en", ram_en, 0);
    repeat (2) idle();
    // Write from req0 followed by read of the same word from req1.
    step(1, 1, 16'h0003, 8'h3C, 0, 0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 1, 0, 16'h0003, 0, 1, 8'h3C, 0);
    repeat (3) idle();
    // Only req1 streams reads of 0..3 with no bubbles.
    step(0, 0, 0, 0, 1, 0, 16'd0, 0, 1, 8'h10, 0);
    step(0, 0, 0, 0, 1, 0, 16'd1, 0, 1, 8'h11, 0);
    step(0, 0, 0, 0, 1, 0, 16'd2, 0, 1, 8'h12, 0);
    step(0, 0, 0, 0, 1, 0, 16'd3, 0, 1, 8'h3C, 0);
    repeat (3) idle();
    // Reset right after a read accept drops it; the next tie goes to req0.
    step(1, 0, 16'd7, 0, 0, 0, 0, 0, 0, 8'h17, 0);
    do_reset(1);
    repeat (3) idle();
    step(1, 0, 16'd1, 0, 1, 0, 16'd2, 0, 0, 8'h11, 0);
    step(0, 0, 0, 0, 1, 0, 16'd2, 0, 1, 8'h12, 0);
    repeat (4) idle();
    check("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
